dmem_access: RTL and testbench

DMEM_ACCESS -- requirements
Module: dmem_access

---
 rtl/dmem_access_if.sv | 11 +
 rtl/dmem_access.sv | 91 +++++++++
 tb/tb_dmem_access.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// dmem_access_if: data-memory request/response bus between the MEM stage and memory.
interface dmem_access_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, input mem_ack_i, mem_rdata_i);
    modport slave (input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage data-memory access FSM with pipeline stall and misalignment fault.
// Defining DMEM_ACCESS_TIMEOUT_EN adds an 8-bit BUSY timeout that aborts the access with err_o.
module dmem_access (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [1:0]    MEM_i,
    input  logic [1:0]    WB_i,
    input  logic [31:0]   ALUres_i,
    input  logic [31:0]   wdata_i,
    input  logic [4:0]    RDaddr_i,
    dmem_access_if.master bus,
    output logic [1:0]    WB_o,
    output logic [31:0]   data1_o,
    output logic [31:0]   data2_o,
    output logic [4:0]    RDaddr_o,
    output logic          stall_o,
    output logic          err_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n, cur;
    logic memop, aligned, start, done, timeout;
`ifdef DMEM_ACCESS_TIMEOUT_EN
    logic [7:0] cnt;
    assign timeout = cur == BUSY && !bus.mem_ack_i && cnt == 8'hff;
`else
    assign timeout = 1'b0;
`endif
    assign memop = valid_i && MEM_i != 2'b00;
    assign aligned = ALUres_i[1:0] == 2'b00;
    // while reset is asserted the outputs behave as IDLE whatever the stored state
    assign cur = rst_i ? state : IDLE;
    assign data2_o = ALUres_i;
    assign RDaddr_o = RDaddr_i;

    always_comb begin
        state_n = cur;
        start = 1'b0;
        done = 1'b0;
        WB_o = 2'b00;
        data1_o = '0;
        stall_o = 1'b0;
        err_o = 1'b0;
        if (cur == IDLE) begin
            if (!memop) WB_o = valid_i ? WB_i : 2'b00;
            else if (aligned) begin
                stall_o = 1'b1;
                start = 1'b1;
                state_n = BUSY;
            end else err_o = 1'b1;
        end else if (bus.mem_ack_i) begin
            WB_o = WB_i;
            data1_o = bus.mem_we_o ? '0 : bus.mem_rdata_i;
            done = 1'b1;
            state_n = IDLE;
        end else if (timeout) begin
            err_o = 1'b1;
            done = 1'b1;
            state_n = IDLE;
        end else stall_o = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o <= 1'b0;
            bus.mem_addr_o <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                bus.mem_req_o <= 1'b1;
                bus.mem_we_o <= MEM_i == 2'b01;
                bus.mem_addr_o <= ALUres_i;
                bus.mem_wdata_o <= wdata_i;
            end
            if (done) begin
                bus.mem_req_o <= 1'b0;
                bus.mem_we_o <= 1'b0;
            end
        end
    end

`ifdef DMEM_ACCESS_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i || start) cnt <= '0;
        else if (cur == BUSY && !bus.mem_ack_i) cnt <= cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: table-driven IDLE vectors plus scoreboarded memory-access sequences.
module tb_dmem_access;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i;
    logic [1:0]  MEM_i, WB_i, WB_o;
    logic [31:0] ALUres_i, wdata_i, data1_o, data2_o;
    logic [4:0]  RDaddr_i, RDaddr_o;
    logic        stall_o, err_o;
    int checks = 0;
    int errors = 0;

    dmem_access_if bus();

    dmem_access dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .MEM_i(MEM_i), .WB_i(WB_i),
        .ALUres_i(ALUres_i), .wdata_i(wdata_i), .RDaddr_i(RDaddr_i), .bus(bus),
        .WB_o(WB_o), .data1_o(data1_o), .data2_o(data2_o), .RDaddr_o(RDaddr_o),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [1:0]  mem;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        ack;
        logic [1:0]  wb_x;
        logic        err_x;
    } vec_t;

    typedef struct {
        logic [31:0] data1;
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] alu;
    } sb_t;

    sb_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] mem, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        valid_i = v;
        MEM_i = mem;
        WB_i = wb;
        ALUres_i = alu;
        wdata_i = wd;
        RDaddr_i = rd;
    endtask

    task automatic idle_nop();
        @(negedge clk_i);
        drive(1'b1, 2'b00, 2'b01, 32'h0000_0abc, 32'h0, 5'd2);
        bus.mem_ack_i = 1'b0;
        #1;
        chk("nop_req", bus.mem_req_o, 1'b0);
        chk("nop_we", bus.mem_we_o, 1'b0);
        chk("nop_stall", stall_o, 1'b0);
        chk("nop_wb", WB_o, 2'b01);
    endtask

    task automatic do_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input logic [1:0] wb, input logic [4:0] rd,
                          input int wait_n);
        sb_t e;
        int nstall;
        @(negedge clk_i);
        drive(1'b1, st ? 2'b01 : 2'b10, wb, addr, wd, rd);
        bus.mem_ack_i = 1'b0;
        #1;
        chk("detect_req", bus.mem_req_o, 1'b0);
        chk("detect_stall", stall_o, 1'b1);
        chk("detect_wb", WB_o, 2'b00);
        nstall = int'(stall_o);
        e.data1 = st ? 32'h0 : rdat;
        e.wb = wb;
        e.rd = rd;
        e.alu = addr;
        sb.push_back(e);
        for (int i = 0; i <= wait_n; i++) begin
            @(negedge clk_i);
            bus.mem_ack_i = (i == wait_n);
            bus.mem_rdata_i = (i == wait_n) ? rdat : 32'h0bad_0000 ^ i;
            #1;
            chk("busy_req", bus.mem_req_o, 1'b1);
            chk("busy_we", bus.mem_we_o, st);
            chk("busy_addr", bus.mem_addr_o, addr);
            chk("busy_wdata", bus.mem_wdata_o, wd);
            if (i < wait_n) begin
                chk("busy_stall", stall_o, 1'b1);
                chk("busy_wb", WB_o, 2'b00);
                chk("busy_err", err_o, 1'b0);
                nstall += int'(stall_o);
            end
        end
        e = sb.pop_front();
        chk("ack_stall", stall_o, 1'b0);
        chk("ack_err", err_o, 1'b0);
        chk("ack_wb", WB_o, e.wb);
        chk("ack_data1", data1_o, e.data1);
        chk("ack_data2", data2_o, e.alu);
        chk("ack_rd", RDaddr_o, e.rd);
        chk("stall_cycles", nstall, 1 + wait_n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 2'b00, 2'b10, 32'h0000_1234, 5'd3,  1'b0, 2'b10, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 2'b11, 32'h0000_0005, 5'd4,  1'b0, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 2'b10, 2'b01, 32'h0000_0102, 5'd5,  1'b0, 2'b00, 1'b1};
        vecs[3] = '{1'b1, 2'b01, 2'b11, 32'h0000_0003, 5'd6,  1'b0, 2'b00, 1'b1};
        vecs[4] = '{1'b1, 2'b11, 2'b10, 32'h0000_0101, 5'd7,  1'b0, 2'b00, 1'b1};
        vecs[5] = '{1'b0, 2'b00, 2'b11, 32'hffff_ffff, 5'd8,  1'b1, 2'b00, 1'b0};
        vecs[6] = '{1'b1, 2'b00, 2'b11, 32'hffff_fffe, 5'd31, 1'b1, 2'b11, 1'b0};
        vecs[7] = '{1'b0, 2'b10, 2'b01, 32'h0000_0200, 5'd9,  1'b1, 2'b00, 1'b0};

        drive(1'b1, 2'b00, 2'b01, 32'h0000_0010, 32'h0, 5'd1);
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_req", bus.mem_req_o, 1'b0);
        chk("rst_we", bus.mem_we_o, 1'b0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_wb", WB_o, 2'b01);
        rst_i = 1'b1;

        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            drive(vecs[k].v, vecs[k].mem, vecs[k].wb, vecs[k].alu, 32'h1357_9bdf, vecs[k].rd);
            bus.mem_ack_i = vecs[k].ack;
            bus.mem_rdata_i = 32'hffff_0000;
            #1;
            chk($sformatf("vec%0d_wb", k), WB_o, vecs[k].wb_x);
            chk($sformatf("vec%0d_data2", k), data2_o, vecs[k].alu);
            chk($sformatf("vec%0d_rd", k), RDaddr_o, vecs[k].rd);
            chk($sformatf("vec%0d_data1", k), data1_o, 32'h0);
            chk($sformatf("vec%0d_stall", k), stall_o, 1'b0);
            chk($sformatf("vec%0d_err", k), err_o, vecs[k].err_x);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_noreq", k), bus.mem_req_o, 1'b0);
        end

        do_mem(1'b0, 32'h0000_0100, 32'h1111_1111, 32'hdead_beef, 2'b10, 5'd7, 3);
        idle_nop();
        do_mem(1'b1, 32'h0000_0040, 32'ha5a5_a5a5, 32'h7777_7777, 2'b00, 5'd0, 1);
        idle_nop();
        do_mem(1'b0, 32'h0000_0008, 32'h0, 32'h0102_0304, 2'b11, 5'd10, 0);
        do_mem(1'b1, 32'h0000_000c, 32'hcafe_f00d, 32'h5555_aaaa, 2'b01, 5'd11, 2);
        do_mem(1'b0, 32'h0000_0010, 32'h0, 32'h8765_4321, 2'b10, 5'd12, 0);
        idle_nop();
`ifdef DMEM_ACCESS_TIMEOUT_EN
        do_mem(1'b0, 32'h0000_1000, 32'h0, 32'h600d_ac4e, 2'b10, 5'd13, 255);
        idle_nop();
        begin
            int bad = 0;
            @(negedge clk_i);
            drive(1'b1, 2'b10, 2'b10, 32'h0000_0200, 32'h0, 5'd14);
            bus.mem_ack_i = 1'b0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk_i);
                #1;
                if (i < 255) bad += int'(err_o || !stall_o || !bus.mem_req_o);
                else begin
                    chk("to_err", err_o, 1'b1);
                    chk("to_stall", stall_o, 1'b0);
                    chk("to_wb", WB_o, 2'b00);
                end
            end
            chk("to_wait_ok", bad, 0);
            @(negedge clk_i);
            drive(1'b1, 2'b00, 2'b10, 32'h0, 32'h0, 5'd14);
            #1;
            chk("to_req_off", bus.mem_req_o, 1'b0);
            chk("to_err_pulse", err_o, 1'b0);
            chk("to_released", stall_o, 1'b0);
        end
`else
        do_mem(1'b0, 32'h0000_1000, 32'h0, 32'h600d_ac4e, 2'b10, 5'd13, 300);
        idle_nop();
`endif
        @(negedge clk_i);
        drive(1'b1, 2'b10, 2'b11, 32'h0000_0300, 32'h0, 5'd15);
        bus.mem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rb_req", bus.mem_req_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 2'b00, 2'b10, 32'h0000_0055, 32'h0, 5'd16);
        #1;
        chk("rb_rst_stall", stall_o, 1'b0);
        chk("rb_rst_wb", WB_o, 2'b10);
        chk("rb_rst_err", err_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'hdead_beef;
        #1;
        chk("rb_req_off", bus.mem_req_o, 1'b0);
        chk("rb_addr_clr", bus.mem_addr_o, 32'h0);
        chk("rb_late_stall", stall_o, 1'b0);
        chk("rb_late_wb", WB_o, 2'b10);
        chk("rb_late_data1", data1_o, 32'h0);
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        #1;
        chk("rb_still_idle", bus.mem_req_o, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
